neuron_mac: RTL and testbench

Signed multiply-accumulate neuron datapath for the MLP core. It consumes one weight/input pair per handshake from the SRAM read path, accumulates INPUT_NUM products, then rescales, saturates and activates the sum. It holds the resulting neuron value until the output-write stage accepts it. It sits between the SRAM read ports sequenced by the neuron controller and the output SRAM write path.

---
 rtl/neuron_mac_if.sv | 29 ++
 rtl/neuron_mac.sv | 152 +++++++++++++++
 tb/tb_neuron_mac.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_if.sv
// Handshake bundle between the neuron sequencer/output writer (master) and neuron_mac (slave).
// dbg_state mirrors the MAC state register so checkers can bind to it.
interface neuron_mac_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                         start;
    logic signed [DATA_WIDTH-1:0] weight_in;
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         in_valid;
    logic                         in_ready;
    logic        [DATA_WIDTH-1:0] neuron_out;
    logic                         out_valid;
    logic                         out_ready;
    logic                         busy;
    logic                         overflow;
    logic        [2:0]            dbg_state;

    // Both channels use strict valid/ready: a transfer happens on a rising edge where
    // valid && ready; valid must hold with stable data until accepted, ready may not depend on valid.
    modport master (
        output start, weight_in, data_in, in_valid, out_ready,
        input  in_ready, neuron_out, out_valid, busy, overflow, dbg_state
    );

    modport slave (
        input  start, weight_in, data_in, in_valid, out_ready,
        output in_ready, neuron_out, out_valid, busy, overflow, dbg_state
    );
endinterface

// File: rtl/neuron_mac.sv
// Signed multiply-accumulate neuron: INPUT_NUM products, rescale, saturate, activate, hold.
// Build option: define MLP_RELU_EN for a ReLU activation; otherwise the activation is identity.
module neuron_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int FRAC_BITS  = 4,
    parameter int INPUT_NUM  = 4
) (
    input logic         clk,
    input logic         reset,
    neuron_mac_if.slave bus
);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int CNT_W  = $clog2(INPUT_NUM + 1);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACCUM    = 3'd1,
        S_DRAIN    = 3'd2,
        S_ACTIVATE = 3'd3,
        S_HOLD     = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic        [CNT_W-1:0]      count_q, count_d;
    logic signed [PROD_W-1:0]     prod_q, prod_d;
    logic                         prod_valid_q, prod_valid_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic        [DATA_WIDTH-1:0] out_q, out_d;
    logic                         overflow_q, overflow_d;

    logic signed [ACC_WIDTH:0]    sum_ext;
    logic                         sum_ovf;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic signed [DATA_WIDTH-1:0] y_sat;
    logic                         y_clamped;
    logic        [DATA_WIDTH-1:0] act_y;

    // One guard bit is enough to detect a wrap of acc + sext(prod).
    assign sum_ext = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(prod_q);
    assign sum_ovf = sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1];
    assign shifted = acc_q >>> FRAC_BITS;

    always_comb begin
        y_sat     = shifted[DATA_WIDTH-1:0];
        y_clamped = 1'b0;
        if (shifted > OUT_MAX) begin
            y_sat     = OUT_MAX[DATA_WIDTH-1:0];
            y_clamped = 1'b1;
        end else if (shifted < OUT_MIN) begin
            y_sat     = OUT_MIN[DATA_WIDTH-1:0];
            y_clamped = 1'b1;
        end
`ifdef MLP_RELU_EN
        act_y = y_sat[DATA_WIDTH-1] ? '0 : y_sat;
`else
        act_y = y_sat;
`endif
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        prod_d       = prod_q;
        prod_valid_d = 1'b0;
        acc_d        = acc_q;
        out_d        = out_q;
        overflow_d   = overflow_q;

        // Accumulate stage runs independently of the state, one cycle behind the multiplier.
        if (prod_valid_q) begin
            if (sum_ovf) begin
                acc_d      = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
                overflow_d = 1'b1;
            end else begin
                acc_d = sum_ext[ACC_WIDTH-1:0];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d        = '0;
                    count_d      = '0;
                    prod_valid_d = 1'b0;
                    overflow_d   = 1'b0;
                    state_d      = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.in_valid) begin
                    prod_d       = PROD_W'($signed(bus.weight_in)) * PROD_W'($signed(bus.data_in));
                    prod_valid_d = 1'b1;
                    count_d      = count_q + 1'b1;
                    if (count_q == CNT_W'(INPUT_NUM - 1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_ACTIVATE;
            end
            S_ACTIVATE: begin
                out_d   = act_y;
                state_d = S_HOLD;
                if (y_clamped) begin
                    overflow_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            acc_q        <= '0;
            out_q        <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            prod_q       <= prod_d;
            prod_valid_q <= prod_valid_d;
            acc_q        <= acc_d;
            out_q        <= out_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.in_ready   = (state_q == S_ACCUM);
    assign bus.out_valid  = (state_q == S_HOLD);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.neuron_out = out_q;
    assign bus.overflow   = overflow_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: table of neuron vectors fed through a scoreboard queue,
// plus hand-written backpressure and mid-accumulation reset sequences.
module tb_neuron_mac;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int W  = DW + 1;

    typedef struct {
        logic signed [DW-1:0] w[N];
        logic signed [DW-1:0] d[N];
        bit                   bubbles;
        logic [DW-1:0]        exp_out;
        bit                   exp_ovf;
    } vec_t;

    logic clk;
    logic reset;
    neuron_mac_if #(.DATA_WIDTH(DW)) bus ();

    neuron_mac dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    vec_t vecs[9];

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact sum, accumulator clamp, arithmetic rescale, output clamp, activation.
    function automatic logic [W-1:0] model(input logic signed [DW-1:0] w[N],
                                           input logic signed [DW-1:0] d[N]);
        int sum;
        int s;
        bit ovf;
        int y;
        sum = 0;
        ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            sum += int'(w[i]) * int'(d[i]);
            if (sum > 524287) begin sum = 524287; ovf = 1'b1; end
            if (sum < -524288) begin sum = -524288; ovf = 1'b1; end
        end
        s = sum >>> 4;
        y = s;
        if (s > 127) begin y = 127; ovf = 1'b1; end
        if (s < -128) begin y = -128; ovf = 1'b1; end
`ifdef MLP_RELU_EN
        if (y < 0) y = 0;
`endif
        return {ovf, 8'(y)};
    endfunction

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.weight_in = '0;
        bus.data_in   = '0;
    endtask

    // Driver: one full neuron; optional extra HOLD cycles with start/in_valid noise.
    task automatic run_neuron(input vec_t v, input int hold_cycles);
        int lat;
        logic [W-1:0] exp;
        logic [DW-1:0] held;
        check("idle_before_start", bus.busy, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("in_ready_after_start", bus.in_ready, 1);
        check("overflow_cleared_by_start", bus.overflow, 0);
        exp_q.push_back({v.exp_ovf, v.exp_out});
        for (int i = 0; i < N; i++) begin
            bus.in_valid  = 1'b1;
            bus.weight_in = v.w[i];
            bus.data_in   = v.d[i];
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (v.bubbles && i < N - 1) begin
                bus.weight_in = DW'($urandom_range(0, 255));
                bus.data_in   = DW'($urandom_range(0, 255));
                @(negedge clk);
                check("in_ready_during_bubble", bus.in_ready, 1);
            end
        end
        check("in_ready_low_in_drain", bus.in_ready, 0);
        lat = 0;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_seen", bus.out_valid, 1);
        check("output_latency", lat, 2);
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            exp = exp_q.pop_front();
            check("neuron_out", bus.neuron_out, exp[DW-1:0]);
            check("overflow", bus.overflow, exp[DW]);
        end
        held = bus.neuron_out;
        for (int k = 0; k < hold_cycles; k++) begin
            bus.start     = 1'b1;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.weight_in = DW'($urandom_range(0, 255));
            bus.data_in   = DW'($urandom_range(0, 255));
            @(negedge clk);
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_neuron_out_stable", bus.neuron_out, held);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_busy", bus.busy, 1);
        end
        // start alongside out_ready in HOLD must be ignored.
        bus.start     = (hold_cycles > 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        check("release_out_valid", bus.out_valid, 0);
        check("release_busy", bus.busy, 0);
        check("release_state_idle", bus.dbg_state, 0);
    endtask

    initial begin
        vec_t v;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_overflow", bus.overflow, 0);
        check("reset_neuron_out", bus.neuron_out, 0);
        check("reset_state", bus.dbg_state, 0);
        reset = 1'b0;
        @(negedge clk);

        vecs[0] = '{w: '{16, 16, 16, 16}, d: '{1, 2, 3, 4}, bubbles: 0, exp_out: 8'd10, exp_ovf: 0};
`ifdef MLP_RELU_EN
        vecs[1] = '{w: '{-16, -16, -16, -16}, d: '{5, 5, 5, 5}, bubbles: 0, exp_out: 8'h00, exp_ovf: 0};
`else
        vecs[1] = '{w: '{-16, -16, -16, -16}, d: '{5, 5, 5, 5}, bubbles: 0, exp_out: 8'hEC, exp_ovf: 0};
`endif
        vecs[2] = '{w: '{127, 127, 127, 127}, d: '{127, 127, 127, 127}, bubbles: 0, exp_out: 8'd127, exp_ovf: 1};
        vecs[3] = '{w: '{16, 16, 16, 16}, d: '{1, 2, 3, 4}, bubbles: 1, exp_out: 8'd10, exp_ovf: 0};
        vecs[4] = '{w: '{-128, -128, -128, -128}, d: '{127, 127, 127, 127}, bubbles: 0,
`ifdef MLP_RELU_EN
                    exp_out: 8'h00, exp_ovf: 1};
`else
                    exp_out: 8'h80, exp_ovf: 1};
`endif
        for (int i = 5; i < 9; i++) begin
            for (int j = 0; j < N; j++) begin
                v.w[j] = DW'($urandom_range(0, 255));
                v.d[j] = DW'($urandom_range(0, 40));
            end
            v.bubbles = 1'($urandom_range(0, 1));
            {v.exp_ovf, v.exp_out} = model(v.w, v.d);
            vecs[i] = v;
        end

        for (int i = 0; i < 9; i++) begin
            run_neuron(vecs[i], 0);
        end

        // Backpressure: five HOLD cycles with start and in_valid noise.
        run_neuron(vecs[0], 5);

        // Reset in the middle of ACCUM after two pairs.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid  = 1'b1;
            bus.weight_in = 8'sd16;
            bus.data_in   = 8'(i + 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("mid_accum_busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("async_reset_busy", bus.busy, 0);
        check("async_reset_in_ready", bus.in_ready, 0);
        check("async_reset_out_valid", bus.out_valid, 0);
        check("async_reset_neuron_out", bus.neuron_out, 0);
        check("async_reset_overflow", bus.overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_neuron(vecs[0], 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
